// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states, default latencies.
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_MTHI  = 4'd3;
    localparam logic [3:0] OP_MTLO  = 4'd4;
    localparam logic [3:0] OP_DIV   = 4'd5;
    localparam logic [3:0] OP_DIVU  = 4'd6;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/mdu_ctrl.sv
// HI/LO multiply-divide controller: accepts MDU ops from E stage, models
// multi-cycle latency with a down-counter and commits results to HI/LO.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    input  logic        use_d,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_LAST = 4'(MULT_CYC - 1);
    localparam logic [3:0] DIV_LAST  = 4'(DIV_CYC - 1);

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [31:0] p_hi;
    logic [31:0] p_lo;

    logic        op_valid;
    logic        op_long;
    logic        accept;
    logic        rt_zero;

    logic signed [63:0] rs_sx;
    logic signed [63:0] rt_sx;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;

    assign op_valid = (op >= OP_MULT) && (op <= OP_DIVU);
    assign op_long  = (op == OP_MULT) || (op == OP_MULTU) ||
                      (op == OP_DIV)  || (op == OP_DIVU);
    assign accept   = start && !flush && (state == IDLE) && op_valid;
    assign rt_zero  = (rt_val == 32'd0);

    assign busy  = (state == RUN);
    assign stall = use_d & (busy | (start & op_long));

    // Arithmetic for all op types; only the selected result is captured on accept.
    always_comb begin
        rs_sx  = {{32{rs_val[31]}}, rs_val};
        rt_sx  = {{32{rt_val[31]}}, rt_val};
        prod_s = rs_sx * rt_sx;
        prod_u = {32'd0, rs_val} * {32'd0, rt_val};
        quot_s = 32'sd0;
        rem_s  = 32'sd0;
        quot_u = 32'd0;
        rem_u  = 32'd0;
        if (!rt_zero) begin
            quot_s = $signed(rs_val) / $signed(rt_val);
            rem_s  = $signed(rs_val) % $signed(rt_val);
            quot_u = rs_val / rt_val;
            rem_u  = rs_val % rt_val;
        end
    end

    // Next state: enter RUN on an accepted mult/div, leave RUN when the counter expires.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && op_long) state_nx = RUN;
            RUN:     if (cnt == 4'd0)       state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // All sequential state: FSM, countdown, pending result and architectural HI/LO.
    // A divide by zero preloads the pending regs with the current HI/LO so the
    // completion commit leaves them unchanged (HI/LO cannot change while in RUN).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
            p_hi  <= 32'd0;
            p_lo  <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                if (accept) begin
                    case (op)
                        OP_MULT: begin
                            {p_hi, p_lo} <= prod_s;
                            cnt          <= MULT_LAST;
                        end
                        OP_MULTU: begin
                            {p_hi, p_lo} <= prod_u;
                            cnt          <= MULT_LAST;
                        end
                        OP_DIV: begin
                            p_hi <= rt_zero ? hi : rem_s;
                            p_lo <= rt_zero ? lo : quot_s;
                            cnt  <= DIV_LAST;
                        end
                        OP_DIVU: begin
                            p_hi <= rt_zero ? hi : rem_u;
                            p_lo <= rt_zero ? lo : quot_u;
                            cnt  <= DIV_LAST;
                        end
                        OP_MTHI: hi <= rs_val;
                        OP_MTLO: lo <= rs_val;
                        default: ;
                    endcase
                end
            end else begin
                if (cnt == 4'd0) begin
                    hi <= p_hi;
                    lo <= p_lo;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed testbench for mdu_ctrl: vector table for single ops plus
// hand-written sequences for flush, stall, completion-cycle start and reset.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        use_d;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        int          cycles;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    mdu_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .flush  (flush),
        .use_d  (use_d),
        .busy   (busy),
        .stall  (stall),
        .hi     (hi),
        .lo     (lo)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Present one op for one cycle; returns 1 ns after the edge that samples it.
    task automatic applyStimulus(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs_val = a;
        rt_val = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = OP_NONE;
    endtask

    // Count busy cycles at negedges; optionally pulse flush on one of them.
    task automatic countBusy(input int flushAt, output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            flush = (i == flushAt);
            if (!busy) break;
            n++;
        end
        flush = 1'b0;
        if (n >= 40) begin
            errors++;
            $display("[TB] FAIL busy_timeout: got %0d cycles expected fewer than 40", n);
        end
    endtask

    initial begin
        int n;
        vecs[0]  = '{OP_MULT,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFE, 32'd3,        5,  32'h00000002, 32'hFFFFFFFA};
        vecs[2]  = '{OP_DIVU,  32'd7,        32'd2,        10, 32'h00000001, 32'h00000003};
        vecs[3]  = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[5]  = '{OP_DIVU,  32'hFFFFFFF9, 32'd2,        10, 32'h00000001, 32'h7FFFFFFC};
        vecs[6]  = '{OP_MTHI,  32'h00000011, 32'd0,        0,  32'h00000011, 32'h7FFFFFFC};
        vecs[7]  = '{OP_MTLO,  32'h00000022, 32'd0,        0,  32'h00000011, 32'h00000022};
        vecs[8]  = '{OP_DIV,   32'd5,        32'd0,        10, 32'h00000011, 32'h00000022};
        vecs[9]  = '{OP_MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
        vecs[10] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
        vecs[11] = '{4'd9,     32'h12345678, 32'd1,        0,  32'hFFFFFFFE, 32'h00000001};

        rst_n  = 1'b0;
        start  = 1'b0;
        op     = OP_NONE;
        rs_val = 32'd0;
        rt_val = 32'd0;
        flush  = 1'b0;
        use_d  = 1'b0;
        #3;
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single operations.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].op, vecs[i].rs, vecs[i].rt);
            countBusy(-1, n);
            checkOutput($sformatf("vec%0d_cycles", i), 32'(n), 32'(vecs[i].cycles));
            checkOutput($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            checkOutput($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
        end

        // Flushed start is ignored.
        @(negedge clk);
        start = 1'b1; op = OP_MULT; rs_val = 32'd9; rt_val = 32'd9; flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; op = OP_NONE; flush = 1'b0;
        @(negedge clk);
        checkOutput("flush_start_busy", 32'(busy), 32'd0);
        checkOutput("flush_start_hi", hi, 32'hFFFFFFFE);
        checkOutput("flush_start_lo", lo, 32'h00000001);

        // Flush mid-run does not abort.
        applyStimulus(OP_MULT, 32'd6, 32'd7);
        countBusy(2, n);
        checkOutput("flush_run_cycles", 32'(n), 32'd5);
        checkOutput("flush_run_hi", hi, 32'd0);
        checkOutput("flush_run_lo", lo, 32'd42);

        // Stall with use_d held across a MULT.
        @(negedge clk);
        use_d = 1'b1; start = 1'b1; op = OP_MULT; rs_val = 32'd2; rt_val = 32'd3;
        #1;
        checkOutput("stall_start", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0; op = OP_NONE;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!stall) break;
            n++;
        end
        checkOutput("stall_cycles", 32'(n), 32'd5);
        checkOutput("stall_after_busy", 32'(busy), 32'd0);
        checkOutput("stall_after_lo", lo, 32'd6);

        // No stall when use_d is low.
        @(negedge clk);
        use_d = 1'b0; start = 1'b1; op = OP_MULT; rs_val = 32'd4; rt_val = 32'd5;
        #1;
        n = int'(stall);
        @(posedge clk);
        #1;
        start = 1'b0; op = OP_NONE;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (stall) n++;
        end
        checkOutput("nostall_count", 32'(n), 32'd0);
        checkOutput("nostall_lo", lo, 32'd20);

        // Start in the completion cycle is ignored.
        applyStimulus(OP_MULT, 32'd3, 32'd5);
        for (int i = 0; i < 4; i++) @(negedge clk);
        @(negedge clk);
        checkOutput("complete_cycle_busy", 32'(busy), 32'd1);
        start = 1'b1; op = OP_MTHI; rs_val = 32'hAA;
        @(posedge clk);
        #1;
        start = 1'b0; op = OP_NONE;
        @(negedge clk);
        checkOutput("complete_cycle_done", 32'(busy), 32'd0);
        checkOutput("complete_cycle_hi", hi, 32'd0);
        checkOutput("complete_cycle_lo", lo, 32'd15);

        // Asynchronous reset during a DIV discards the result.
        applyStimulus(OP_MTHI, 32'h55, 32'd0);
        applyStimulus(OP_DIV, 32'd100, 32'd7);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_hi", hi, 32'd0);
        checkOutput("rst_mid_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) @(negedge clk);
        checkOutput("rst_nocommit_busy", 32'(busy), 32'd0);
        checkOutput("rst_nocommit_hi", hi, 32'd0);
        checkOutput("rst_nocommit_lo", lo, 32'd0);

        // Accept at the first edge after reset release.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b1; op = OP_MULTU; rs_val = 32'd2; rt_val = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0; op = OP_NONE;
        countBusy(-1, n);
        checkOutput("post_reset_cycles", 32'(n), 32'd5);
        checkOutput("post_reset_lo", lo, 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
